multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle CPU top.
- Executes an RV32I subset (add, sub, and, or, slt, addi, lw, sw, beq) through a five-state FSM.
- Talks to external instruction and data memories over req/ready handshakes, which tolerate wait states.
- Sits at CPU top level, replacing the free-running single-cycle datapath.

Parameters:
- XLEN, 32, datapath/register/address width (32 or 64); immediates sign-extended to XLEN.
- RESET_PC, 0, PC value loaded on reset.
- NUM_REGS, 32, architectural registers (16 or 32); register index bits above log2(NUM_REGS) ignored.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request.
- imem_addr  output  XLEN  fetch byte address (= PC).
- imem_rdata  input  32  instruction word, valid when imem_ready.
- imem_ready  input  1  fetch complete.
- dmem_req  output  1  data access request.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  XLEN  data byte address.
- dmem_wdata  output  XLEN  store data.
- dmem_rdata  input  XLEN  load data, valid when dmem_ready.
- dmem_ready  input  1  data access complete.
- illegal  output  1  sticky: unsupported opcode/funct seen.
- pc_out  output  XLEN  current PC, for debug.

Behaviour:
- Reset (synchronous, active-high), applied at the next edge:
  - PC = RESET_PC; state = FETCH.
  - All registers = 0; illegal = 0.
  - imem_req, dmem_req, dmem_we = 0; dmem_addr, dmem_wdata = 0.
  - Reset mid-transaction drops the req in the same edge; a pending ready is ignored.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- FETCH:
  - imem_req = 1, imem_addr = PC, held stable until imem_ready.
  - On an edge with imem_ready = 1: latch IR, go to DECODE. imem_req may deassert the following cycle.
- DECODE (1 cycle):
  - Read rs1 (IR[19:15]) and rs2 (IR[24:20]) into A/B; build the sign-extended immediate (I, S or B format).
  - Unsupported opcode/funct3/funct7: illegal = 1, go to TRAP.
- EXECUTE (1 cycle):
  - R-type: ALUOut = A op B. slt is a signed compare giving 1 or 0.
  - addi: ALUOut = A + imm.
  - lw/sw: ALUOut = A + imm, then go to MEM.
  - beq: if A == B, PC = PC + imm; else PC = PC + 4; then go to FETCH.
  - R/addi: go to WRITEBACK.
- MEM:
  - dmem_req = 1; dmem_addr = ALUOut; for sw, dmem_we = 1 and dmem_wdata = B.
  - Outputs held until dmem_ready.
  - On dmem_ready: lw latches dmem_rdata into MDR and goes to WRITEBACK; sw sets PC = PC + 4 and goes to FETCH.
- WRITEBACK (1 cycle):
  - rd (IR[11:7]) = ALUOut, or MDR for lw; PC = PC + 4; go to FETCH.
  - Writes to x0 are discarded; x0 always reads 0.
- TRAP: absorbing; no requests issued; only reset leaves it.
- Latency, with zero-wait memory (ready high in the first request cycle):
  - beq: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Arithmetic:
  - All arithmetic is modulo 2^XLEN; PC + 4 wraps from 2^XLEN−4 to 0.
  - Branch offsets are sign-extended, and bit 0 of the offset is forced to 0.
- Memory:
  - Loads and stores transfer a full XLEN word; no byte lanes or alignment check.
  - imem_ready or dmem_ready asserted while the corresponding req is low is ignored.
- pc_out always equals the internal PC.

Optional Feature:
- Macro CPU_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt (64) and instret_cnt (64).
  - cycle_cnt increments every cycle after reset, except in TRAP.
  - instret_cnt increments on each instruction completion: WRITEBACK exit, sw MEM exit, beq EXECUTE exit.
  - Both clear on reset and wrap at 2^64.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 0x100 → pc_out = 0x100, imem_req = 1 on the first cycle after reset deasserts, illegal = 0.
- addi x1,x0,5; addi x2,x0,−3; add x3,x1,x2; slt x4,x2,x1 (zero-wait) → x3 = 2, x4 = 1, total 16 cycles, PC = RESET_PC + 16.
- sw x1,8(x0) then lw x5,8(x0), with dmem_ready delayed 3 cycles each → dmem_addr = 8 and dmem_wdata = 5 held stable during the wait; x5 = 5; sw takes 7 cycles, lw 8.
- beq x1,x1,−8 at PC 0x20 → next fetch at 0x18; beq x1,x2,+16 (not taken) → next fetch at 0x24.
- addi x0,x0,7, then add x6,x0,x0 → x6 = 0. Opcode 0x7F → illegal = 1, no further imem_req until reset.
- reset asserted while imem_req = 1 and imem_ready = 0 → imem_req = 0 and pc_out = RESET_PC at the next edge. With CPU_PERF_CNT_EN: after the addi/add sequence, instret_cnt = 4 and cycle_cnt ≥ 16.

Source files
------------

// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle RV32I-subset core with req/ready memory ports
// Optional performance counters (cycle_cnt, instret_cnt) enabled by CPU_PERF_CNT_EN.
module multicycle_core #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
`ifdef CPU_PERF_CNT_EN
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt,
`endif
  output logic            illegal,
  output logic [XLEN-1:0] pc_out
);

  localparam int RIDX = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic            illegal_q, illegal_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic [XLEN-1:0] rf_d [NUM_REGS];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RIDX-1:0] rs1, rs2, rd;
  logic            is_r, r_ok, is_addi, is_lw, is_sw, is_beq, legal;
  logic [XLEN-1:0] imm, r_result, mem_ea;

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign funct7  = ir_q[31:25];
  assign rs1     = ir_q[15 +: RIDX];
  assign rs2     = ir_q[20 +: RIDX];
  assign rd      = ir_q[7 +: RIDX];

  assign is_r    = (opcode == 7'h33);
  assign is_addi = (opcode == 7'h13) && (funct3 == 3'b000);
  assign is_lw   = (opcode == 7'h03) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'h23) && (funct3 == 3'b010);
  assign is_beq  = (opcode == 7'h63) && (funct3 == 3'b000);
  assign r_ok    = is_r && (((funct7 == 7'h00) && (funct3 == 3'b000 || funct3 == 3'b010 ||
                                                  funct3 == 3'b110 || funct3 == 3'b111)) ||
                            ((funct7 == 7'h20) && (funct3 == 3'b000)));
  assign legal   = r_ok || is_addi || is_lw || is_sw || is_beq;
  assign mem_ea  = a_q + imm_q;

  // B-format offsets carry an implicit zero in bit 0
  always_comb begin
    imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    if (opcode == 7'h23)
      imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    else if (opcode == 7'h63)
      imm = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  end

  always_comb begin
    r_result = a_q + b_q;
    case (funct3)
      3'b000:  r_result = funct7[5] ? (a_q - b_q) : (a_q + b_q);
      3'b010:  r_result = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      3'b110:  r_result = a_q | b_q;
      3'b111:  r_result = a_q & b_q;
      default: r_result = a_q + b_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    imm_d        = imm_q;
    alu_d        = alu_q;
    mdr_d        = mdr_q;
    illegal_d    = illegal_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_d         = rf_q;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs1];
        b_d   = rf_q[rs2];
        imm_d = imm;
        if (legal) begin
          state_d = S_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXECUTE: begin
        if (is_beq) begin
          pc_d    = (a_q == b_q) ? (pc_q + imm_q) : (pc_q + XLEN'(4));
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          alu_d       = mem_ea;
          dmem_req_d  = 1'b1;
          dmem_we_d   = is_sw;
          dmem_addr_d = mem_ea;
          if (is_sw)
            dmem_wdata_d = b_q;
          state_d = S_MEM;
        end else if (is_r) begin
          alu_d   = r_result;
          state_d = S_WRITEBACK;
        end else begin
          alu_d   = a_q + imm_q;
          state_d = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ready) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (is_lw) begin
            mdr_d   = dmem_rdata;
            state_d = S_WRITEBACK;
          end else begin
            pc_d    = pc_q + XLEN'(4);
            state_d = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        rf_d[rd] = is_lw ? mdr_q : alu_q;
        pc_d     = pc_q + XLEN'(4);
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
    rf_d[0]    = '0;
    imem_req_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      alu_q        <= '0;
      mdr_q        <= '0;
      illegal_q    <= 1'b0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      imm_q        <= imm_d;
      alu_q        <= alu_d;
      mdr_q        <= mdr_d;
      illegal_q    <= illegal_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= rf_d[i];
    end
  end

`ifdef CPU_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;
  logic        retire;

  assign retire = (state_q == S_WRITEBACK) ||
                  (state_q == S_EXECUTE && is_beq) ||
                  (state_q == S_MEM && is_sw && dmem_req_q && dmem_ready);

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + {63'd0, (state_q != S_TRAP)};
    instret_cnt_d = instret_cnt_q + {63'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign illegal    = illegal_q;
  assign pc_out     = pc_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - directed-vector bench for multicycle_core
module tb_multicycle_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic        illegal;
  logic [31:0] pc_out;
`ifdef CPU_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int vectors = 0, miscompares = 0, cyc = 0;
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;

  always #5 clk = ~clk;

  multicycle_core #(.XLEN(32), .RESET_PC(32'h100), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
`ifdef CPU_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .illegal(illegal), .pc_out(pc_out)
  );

  // Memory responders: ready after iwait/dwait cycles of a held request
  initial begin
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (icnt >= iwait) begin
          imem_ready = 1'b1;
          imem_rdata = imem[imem_addr[9:2]];
        end else begin
          imem_ready = 1'b0;
          icnt++;
        end
      end else begin
        imem_ready = 1'b0;
        icnt = 0;
      end
      if (dmem_req) begin
        if (dcnt >= dwait) begin
          dmem_ready = 1'b1;
          if (dmem_we) dmem[dmem_addr[9:2]] = dmem_wdata;
          else         dmem_rdata = dmem[dmem_addr[9:2]];
        end else begin
          dmem_ready = 1'b0;
          dcnt++;
        end
      end else begin
        dmem_ready = 1'b0;
        dcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'h0000_0063;
      dmem[i] = '0;
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // ALU sequence, zero-wait memory
    clear_mem();
    imem[64] = 32'h0050_0093;  // addi x1,x0,5
    imem[65] = 32'hFFD0_0113;  // addi x2,x0,-3
    imem[66] = 32'h0020_81B3;  // add  x3,x1,x2
    imem[67] = 32'h0011_2233;  // slt  x4,x2,x1
    imem[68] = 32'h0430_2023;  // sw   x3,64(x0)
    imem[69] = 32'h0440_2223;  // sw   x4,68(x0)
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst_pc", {32'd0, pc_out}, 64'h100);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_dmem_we", {63'd0, dmem_we}, 64'd0);
    chk("rst_dmem_addr", {32'd0, dmem_addr}, 64'd0);
    chk("rst_dmem_wdata", {32'd0, dmem_wdata}, 64'd0);
    reset = 1'b0;
    cyc = 0;
    step_to(1);
    chk("a_first_req", {63'd0, imem_req}, 64'd1);
    chk("a_first_addr", {32'd0, imem_addr}, 64'h100);
    step_to(2);
    chk("a_req_drop", {63'd0, imem_req}, 64'd0);
    step_to(16);
    chk("a_pc_c16", {32'd0, pc_out}, 64'h10C);
    step_to(17);
    chk("a_pc_c17", {32'd0, pc_out}, 64'h110);
`ifdef CPU_PERF_CNT_EN
    chk("a_instret", instret_cnt, 64'd4);
    chk("a_cycle_ge16", {63'd0, (cycle_cnt >= 64'd16)}, 64'd1);
`endif
    step_to(20);
    chk("a_sw1_req", {62'd0, dmem_req, dmem_we}, 64'd3);
    chk("a_sw1_addr", {32'd0, dmem_addr}, 64'h40);
    chk("a_x3", {32'd0, dmem_wdata}, 64'd2);
    step_to(24);
    chk("a_sw2_addr", {32'd0, dmem_addr}, 64'h44);
    chk("a_x4_slt", {32'd0, dmem_wdata}, 64'd1);
    step_to(25);
    chk("a_pc_c25", {32'd0, pc_out}, 64'h118);
    step_to(30);
    chk("a_mem40", {32'd0, dmem[16]}, 64'd2);
    chk("a_mem44", {32'd0, dmem[17]}, 64'd1);

    // Store then load with three data wait states
    clear_mem();
    imem[64] = 32'h0050_0093;  // addi x1,x0,5
    imem[65] = 32'h0010_2423;  // sw   x1,8(x0)
    imem[66] = 32'h0080_2283;  // lw   x5,8(x0)
    imem[67] = 32'h0050_2623;  // sw   x5,12(x0)
    iwait = 0;
    dwait = 3;
    do_reset();
    step_to(8);
    chk("b_sw_req_c8", {62'd0, dmem_req, dmem_we}, 64'd3);
    chk("b_sw_addr_c8", {32'd0, dmem_addr}, 64'h8);
    chk("b_sw_wdata_c8", {32'd0, dmem_wdata}, 64'd5);
    step_to(10);
    chk("b_sw_req_c10", {62'd0, dmem_req, dmem_we}, 64'd3);
    chk("b_sw_addr_c10", {32'd0, dmem_addr}, 64'h8);
    chk("b_sw_wdata_c10", {32'd0, dmem_wdata}, 64'd5);
    step_to(11);
    chk("b_pc_c11", {32'd0, pc_out}, 64'h104);
    step_to(12);
    chk("b_pc_c12", {32'd0, pc_out}, 64'h108);
    chk("b_dreq_c12", {63'd0, dmem_req}, 64'd0);
    step_to(15);
    chk("b_lw_req_c15", {62'd0, dmem_req, dmem_we}, 64'd2);
    chk("b_lw_addr_c15", {32'd0, dmem_addr}, 64'h8);
    step_to(19);
    chk("b_pc_c19", {32'd0, pc_out}, 64'h108);
    step_to(20);
    chk("b_pc_c20", {32'd0, pc_out}, 64'h10C);
    step_to(26);
    chk("b_x5", {32'd0, dmem_wdata}, 64'd5);
    chk("b_sw2_addr", {32'd0, dmem_addr}, 64'hC);
    step_to(30);
    chk("b_mem12", {32'd0, dmem[3]}, 64'd5);

    // Branches: taken forward, taken backward, not taken
    clear_mem();
    imem[64] = 32'h0050_0093;  // addi x1,x0,5
    imem[65] = 32'hFFD0_0113;  // addi x2,x0,-3
    imem[66] = 32'h0000_0C63;  // beq  x0,x0,+24 -> 0x120
    imem[72] = 32'hFE10_8CE3;  // beq  x1,x1,-8  -> 0x118
    imem[70] = 32'h0020_8863;  // beq  x1,x2,+16 not taken -> 0x11C
    imem[71] = 32'h0410_2823;  // sw   x1,80(x0)
    dwait = 0;
    do_reset();
    step_to(11);
    chk("c_pc_in_beq", {32'd0, pc_out}, 64'h108);
    step_to(12);
    chk("c_fwd_target", {32'd0, imem_addr}, 64'h120);
    step_to(15);
    chk("c_back_target", {32'd0, imem_addr}, 64'h118);
    chk("c_back_req", {63'd0, imem_req}, 64'd1);
    step_to(18);
    chk("c_not_taken", {32'd0, imem_addr}, 64'h11C);
    step_to(21);
    chk("c_sw_addr", {32'd0, dmem_addr}, 64'h50);
    chk("c_sw_x1", {32'd0, dmem_wdata}, 64'd5);

    // x0 stays zero, then an illegal opcode traps
    clear_mem();
    imem[64] = 32'h0070_0013;  // addi x0,x0,7
    imem[65] = 32'h0000_0333;  // add  x6,x0,x0
    imem[66] = 32'h0260_2023;  // sw   x6,32(x0)
    imem[67] = 32'h0000_007F;  // unsupported opcode
    do_reset();
    step_to(12);
    chk("d_sw_addr", {32'd0, dmem_addr}, 64'h20);
    chk("d_x6_zero", {32'd0, dmem_wdata}, 64'd0);
    step_to(14);
    chk("d_illegal_pre", {63'd0, illegal}, 64'd0);
    step_to(15);
    chk("d_illegal_set", {63'd0, illegal}, 64'd1);
    chk("d_trap_ireq_c15", {63'd0, imem_req}, 64'd0);
    step_to(25);
    chk("d_trap_ireq_c25", {63'd0, imem_req}, 64'd0);
    chk("d_trap_dreq_c25", {63'd0, dmem_req}, 64'd0);
    chk("d_trap_illegal", {63'd0, illegal}, 64'd1);
    chk("d_trap_pc", {32'd0, pc_out}, 64'h10C);

    // Reset while a fetch is stalled on wait states
    clear_mem();
    imem[64] = 32'h0050_0093;  // addi x1,x0,5
    iwait = 2;
    do_reset();
    step_to(1);
    chk("e_illegal_clear", {63'd0, illegal}, 64'd0);
    step_to(7);
    chk("e_pc_c7", {32'd0, pc_out}, 64'h104);
    chk("e_req_c7", {63'd0, imem_req}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("e_rst_req_drop", {63'd0, imem_req}, 64'd0);
    chk("e_rst_pc", {32'd0, pc_out}, 64'h100);
    reset = 1'b0;
    @(negedge clk);
    chk("e_refetch_req", {63'd0, imem_req}, 64'd1);
    chk("e_refetch_addr", {32'd0, imem_addr}, 64'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
